fusion_ctrl: RTL

Frame-level sequencer for the per-pixel fusion datapath (old/new frame blend weighted by `del_gauss`). It joins the three input beat streams (old frame, new frame, gauss weight), drives the datapath's global `stall`, and tracks beat validity through the datapath's two-register pipeline. It presents the fused beats as a valid/ready stream with end-of-frame marking, and handles frame start/done signalling to the top-level controller. Pixel data goes straight to the datapath; this block carries control only.

---
 rtl/fusion_ctrl_if.sv | 26 ++
 rtl/fusion_ctrl.sv | 80 ++++++++
 2 files changed

// File: rtl/fusion_ctrl_if.sv
// Control-side handshake bundle between fusion_ctrl and its surroundings.
// master drives start/valids/out_ready; slave is the sequencer.
interface fusion_ctrl_if;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] frame_count;
    logic        old_valid;
    logic        new_valid;
    logic        gauss_valid;
    logic        in_ready;
    logic        fuse_stall;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    modport master (
        output start, old_valid, new_valid, gauss_valid, out_ready,
        input  busy, done, frame_count, in_ready, fuse_stall, out_valid, out_last
    );

    modport slave (
        input  start, old_valid, new_valid, gauss_valid, out_ready,
        output busy, done, frame_count, in_ready, fuse_stall, out_valid, out_last
    );
endinterface

// File: rtl/fusion_ctrl.sv
// Frame sequencer for the fusion datapath: joins old/new/gauss beats, tracks validity.
// Latency: beat accepted at edge k is presented as out_valid after edge k+1.
// Backpressure: out_ready low with a valid output stalls the whole pipe and drops in_ready.
module fusion_ctrl #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int BEATS_PER_FRAME = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT,
    parameter int CNT_W           = $clog2(BEATS_PER_FRAME) + 1
) (
    input  logic         clk,
    input  logic         rst,
    fusion_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   beat_cnt_q;
    logic               v1_q, l1_q, v2_q, l2_q;
    logic               done_q;
    logic [15:0]        frame_cnt_q;

    logic all_valid;
    logic accept;
    logic last_beat;
    logic frame_end;
    logic stall;

    assign all_valid = bus.old_valid & bus.new_valid & bus.gauss_valid;
    assign stall     = v2_q & ~bus.out_ready;
    assign accept    = (state_q == RUN) & ~stall & all_valid;
    assign last_beat = (beat_cnt_q == CNT_W'(BEATS_PER_FRAME - 1));
    assign frame_end = (state_q == DRAIN) & v2_q & l2_q & bus.out_ready;

    assign bus.in_ready    = accept;
    assign bus.fuse_stall  = stall;
    assign bus.out_valid   = v2_q;
    assign bus.out_last    = l2_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.frame_count = frame_cnt_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start)            state_d = RUN;
            RUN:     if (accept && last_beat)  state_d = DRAIN;
            DRAIN:   if (frame_end)            state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            v1_q        <= 1'b0;
            l1_q        <= 1'b0;
            v2_q        <= 1'b0;
            l2_q        <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= frame_end;
            if (frame_end)
                frame_cnt_q <= frame_cnt_q + 16'd1;
            if (state_q == IDLE && bus.start)
                beat_cnt_q <= '0;
            else if (accept)
                beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            // Tracking regs mirror the datapath registers: they hold exactly when it stalls.
            if (!stall) begin
                v1_q <= accept;
                l1_q <= accept & last_beat;
                v2_q <= v1_q;
                l2_q <= l1_q;
            end
        end
    end
endmodule
